// File: rtl/vram_fill_engine.sv
// VRAM fill engine: pattern fill of an address window plus a stalled CPU write path.
// Optional boot-time screen clear is built when VRAM_FILL_AUTOSTART_EN is defined.
module vram_fill_engine #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 1024,
    parameter int COLS   = 60
) (
    input  logic              MEMORY_CLK,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] fill_value,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_din,
    output logic              cpu_ready,
    output logic              v_cea,
    output logic [ADDR_W-1:0] v_ada,
    output logic [DATA_W-1:0] v_din
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(COLS - 1);

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t            state, state_n;
    logic [1:0]        mode_r, mode_n;
    logic [DATA_W-1:0] val_r, val_n;
    logic [ADDR_W-1:0] base_r, base_n;
    logic [CNT_W-1:0]  len_r, len_n;
    logic [CNT_W-1:0]  idx_r, idx_n, row_r, row_n, col_r, col_n;
    logic              cea_n;
    logic [ADDR_W-1:0] ada_n;
    logic [DATA_W-1:0] din_n;

    logic              boot;
    logic              go;
    logic [1:0]        go_mode;
    logic [DATA_W-1:0] go_val;
    logic [ADDR_W-1:0] go_base;
    logic [CNT_W-1:0]  go_len_raw, go_len;

`ifdef VRAM_FILL_AUTOSTART_EN
    logic boot_r;

    // Pending boot clear is consumed by the first IDLE cycle after reset.
    always_ff @(posedge MEMORY_CLK) begin
        if (rst)
            boot_r <= 1'b1;
        else if (state == IDLE)
            boot_r <= 1'b0;
    end

    assign boot = boot_r;
`else
    assign boot = 1'b0;
`endif

    function automatic logic [DATA_W-1:0] pattern(
        input logic [1:0]        m,
        input logic [DATA_W-1:0] v,
        input logic [CNT_W-1:0]  i,
        input logic [CNT_W-1:0]  r,
        input logic [CNT_W-1:0]  c
    );
        case (m)
            2'd0:    pattern = v;
            2'd1:    pattern = v + DATA_W'(i);
            2'd2:    pattern = v + DATA_W'(r);
            default: pattern = (r[0] ^ c[0]) ? ~v : v;
        endcase
    endfunction

    assign go         = (state == IDLE) && (start || boot);
    assign go_mode    = boot ? 2'd0 : mode;
    assign go_val     = boot ? DATA_W'(8'h20) : fill_value;
    assign go_base    = boot ? '0 : base;
    assign go_len_raw = boot ? DEPTH_C : length;
    assign go_len     = (go_len_raw > DEPTH_C) ? DEPTH_C : go_len_raw;

    assign busy      = (state != IDLE) || (boot && !rst);
    assign done      = (state == DONE);
    assign cpu_ready = (state == IDLE) && !start && !boot;

    always_comb begin
        state_n = state;
        mode_n  = mode_r;
        val_n   = val_r;
        base_n  = base_r;
        len_n   = len_r;
        idx_n   = idx_r;
        row_n   = row_r;
        col_n   = col_r;
        cea_n   = 1'b0;
        ada_n   = v_ada;
        din_n   = v_din;
        case (state)
            IDLE: begin
                if (go) begin
                    mode_n = go_mode;
                    val_n  = go_val;
                    base_n = go_base;
                    len_n  = go_len;
                    idx_n  = '0;
                    row_n  = '0;
                    col_n  = '0;
                    if (go_len == '0) begin
                        state_n = DONE;
                    end else begin
                        // Word 0 is issued on the acceptance edge; its pattern is always the seed.
                        state_n = FILL;
                        cea_n   = 1'b1;
                        ada_n   = go_base;
                        din_n   = go_val;
                    end
                end else if (cpu_we && cpu_ready) begin
                    cea_n = 1'b1;
                    ada_n = cpu_addr;
                    din_n = cpu_din;
                end
            end
            FILL: begin
                if (idx_r == len_r - CNT_W'(1)) begin
                    state_n = DONE;
                end else begin
                    idx_n = idx_r + CNT_W'(1);
                    if (col_r == COL_LAST) begin
                        col_n = '0;
                        row_n = row_r + CNT_W'(1);
                    end else begin
                        col_n = col_r + CNT_W'(1);
                    end
                    cea_n = 1'b1;
                    ada_n = base_r + ADDR_W'(idx_n);
                    din_n = pattern(mode_r, val_r, idx_n, row_n, col_n);
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge MEMORY_CLK) begin
        if (rst) begin
            state  <= IDLE;
            mode_r <= '0;
            val_r  <= '0;
            base_r <= '0;
            len_r  <= '0;
            idx_r  <= '0;
            row_r  <= '0;
            col_r  <= '0;
            v_cea  <= 1'b0;
            v_ada  <= '0;
            v_din  <= '0;
        end else begin
            state  <= state_n;
            mode_r <= mode_n;
            val_r  <= val_n;
            base_r <= base_n;
            len_r  <= len_n;
            idx_r  <= idx_n;
            row_r  <= row_n;
            col_r  <= col_n;
            v_cea  <= cea_n;
            v_ada  <= ada_n;
            v_din  <= din_n;
        end
    end

endmodule

// File: tb/tb_vram_fill_engine.sv
// Directed bench for vram_fill_engine: table of fills with probed words, plus CPU/reset sequences.
module tb_vram_fill_engine;

    logic        clk = 1'b0;
    logic        rst, start, cpu_we;
    logic [1:0]  mode;
    logic [7:0]  fill_value, cpu_din;
    logic [9:0]  base, cpu_addr;
    logic [10:0] length;
    logic        busy, done, cpu_ready, v_cea;
    logic [9:0]  v_ada;
    logic [7:0]  v_din;

    always #5 clk = ~clk;

    vram_fill_engine #(.ADDR_W(10), .DATA_W(8), .DEPTH(1024), .COLS(60)) dut (
        .MEMORY_CLK(clk), .rst(rst), .start(start), .mode(mode),
        .fill_value(fill_value), .base(base), .length(length),
        .busy(busy), .done(done), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_din(cpu_din), .cpu_ready(cpu_ready), .v_cea(v_cea),
        .v_ada(v_ada), .v_din(v_din)
    );

    typedef struct {
        logic [1:0]  m;
        logic [7:0]  fv;
        logic [9:0]  b;
        logic [10:0] len;
        int          cnt;
    } fill_t;

    typedef struct {
        int         f;
        int         idx;
        logic [9:0] a;
        logic [7:0] d;
    } probe_t;

    fill_t  fills  [6];
    probe_t probes [16];

    int n_cmp = 0;
    int n_bad = 0;

    logic [9:0] cap_a [1024];
    logic [7:0] cap_d [1024];
    int nw, done_k, done_cnt, gaps;
    logic busy_after;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic run_fill(input logic [1:0] m, input logic [7:0] fv,
                            input logic [9:0] b, input logic [10:0] len);
        @(negedge clk);
        mode = m; fill_value = fv; base = b; length = len; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nw = 0; done_k = -1; done_cnt = 0; gaps = 0; busy_after = 1'b1;
        for (int k = 1; k <= 1100; k++) begin
            if (k > 1) @(negedge clk);
            if (v_cea) begin
                if (nw != k - 1) gaps++;
                if (nw < 1024) begin
                    cap_a[nw] = v_ada;
                    cap_d[nw] = v_din;
                end
                nw++;
            end
            if (done) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
            end
            if (done_k > 0 && k == done_k + 1) begin
                busy_after = busy;
                break;
            end
        end
    endtask

    int bad_ready, cpu_k, fill_w, bad_fill, done_seen;
    logic [7:0] cpu_seen;
    logic found;

    initial begin
        fills[0] = '{2'd0, 8'h41, 10'h000, 11'd4,    4};
        fills[1] = '{2'd1, 8'hFE, 10'h3FE, 11'd4,    4};
        fills[2] = '{2'd2, 8'h00, 10'h000, 11'd121,  121};
        fills[3] = '{2'd3, 8'h55, 10'h100, 11'd62,   62};
        fills[4] = '{2'd1, 8'h10, 10'h020, 11'd0,    0};
        fills[5] = '{2'd1, 8'h00, 10'h005, 11'd2000, 1024};

        probes[0]  = '{0, 0,    10'h000, 8'h41};
        probes[1]  = '{0, 3,    10'h003, 8'h41};
        probes[2]  = '{1, 0,    10'h3FE, 8'hFE};
        probes[3]  = '{1, 1,    10'h3FF, 8'hFF};
        probes[4]  = '{1, 2,    10'h000, 8'h00};
        probes[5]  = '{1, 3,    10'h001, 8'h01};
        probes[6]  = '{2, 59,   10'h03B, 8'h00};
        probes[7]  = '{2, 60,   10'h03C, 8'h01};
        probes[8]  = '{2, 120,  10'h078, 8'h02};
        probes[9]  = '{3, 0,    10'h100, 8'h55};
        probes[10] = '{3, 1,    10'h101, 8'hAA};
        probes[11] = '{3, 59,   10'h13B, 8'hAA};
        probes[12] = '{3, 60,   10'h13C, 8'hAA};
        probes[13] = '{3, 61,   10'h13D, 8'h55};
        probes[14] = '{5, 0,    10'h005, 8'h00};
        probes[15] = '{5, 1023, 10'h004, 8'hFF};

        rst = 1'b1; start = 1'b0; cpu_we = 1'b0; mode = '0; fill_value = '0;
        base = '0; length = '0; cpu_addr = '0; cpu_din = '0;
        repeat (3) @(negedge clk);
        chk("reset v_cea", 32'(v_cea), 32'd0);
        chk("reset v_ada", 32'(v_ada), 32'd0);
        chk("reset v_din", 32'(v_din), 32'd0);
        chk("reset busy",  32'(busy),  32'd0);
        chk("reset done",  32'(done),  32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle busy",      32'(busy),      32'd0);
        chk("idle cpu_ready", 32'(cpu_ready), 32'd1);

        // Plain CPU write in IDLE, then hold of address/data
        cpu_we = 1'b1; cpu_addr = 10'h123; cpu_din = 8'h9A;
        @(negedge clk);
        cpu_we = 1'b0;
        chk("cpu wr cea",  32'(v_cea), 32'd1);
        chk("cpu wr addr", 32'(v_ada), 32'h123);
        chk("cpu wr data", 32'(v_din), 32'h9A);
        @(negedge clk);
        chk("cpu idle cea",  32'(v_cea), 32'd0);
        chk("cpu idle hold", 32'(v_ada), 32'h123);

        // start and cpu_we together: start wins
        mode = 2'd0; fill_value = 8'h11; base = 10'h050; length = 11'd1;
        start = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h0AB; cpu_din = 8'hEE;
        #1;
        chk("collide cpu_ready", 32'(cpu_ready), 32'd0);
        @(negedge clk);
        start = 1'b0; cpu_we = 1'b0;
        chk("collide addr", 32'(v_ada), 32'h050);
        chk("collide data", 32'(v_din), 32'h11);
        repeat (3) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_fill(fills[i].m, fills[i].fv, fills[i].b, fills[i].len);
            chk($sformatf("fill%0d writes", i),      32'(nw),         32'(fills[i].cnt));
            chk($sformatf("fill%0d gaps", i),        32'(gaps),       32'd0);
            chk($sformatf("fill%0d done pulses", i), 32'(done_cnt),   32'd1);
            chk($sformatf("fill%0d done cycle", i),  32'(done_k),     32'(fills[i].cnt + 1));
            chk($sformatf("fill%0d busy after", i),  32'(busy_after), 32'd0);
            for (int p = 0; p < 16; p++) begin
                if (probes[p].f == i) begin
                    chk($sformatf("fill%0d addr[%0d]", i, probes[p].idx),
                        32'(cap_a[probes[p].idx]), 32'(probes[p].a));
                    chk($sformatf("fill%0d data[%0d]", i, probes[p].idx),
                        32'(cap_d[probes[p].idx]), 32'(probes[p].d));
                end
            end
        end

        // CPU write held across a 3-word fill lands right after the return to IDLE
        @(negedge clk);
        mode = 2'd0; fill_value = 8'hC3; base = 10'h200; length = 11'd3; start = 1'b1;
        cpu_we = 1'b1; cpu_addr = 10'h2AA; cpu_din = 8'h77;
        @(negedge clk);
        start = 1'b0;
        bad_ready = 0; cpu_k = -1; fill_w = 0; bad_fill = 0; cpu_seen = '0;
        for (int k = 1; k <= 20; k++) begin
            if (k > 1) @(negedge clk);
            if (busy && cpu_ready) bad_ready++;
            if (v_cea && v_ada == 10'h2AA) begin
                cpu_k = k;
                cpu_seen = v_din;
                cpu_we = 1'b0;
                break;
            end else if (v_cea) begin
                fill_w++;
                if (v_din != 8'hC3) bad_fill++;
            end
        end
        chk("stall ready while busy", 32'(bad_ready), 32'd0);
        chk("stall fill writes",      32'(fill_w),    32'd3);
        chk("stall fill data",        32'(bad_fill),  32'd0);
        chk("stall cpu cycle",        32'(cpu_k),     32'd6);
        chk("stall cpu data",         32'(cpu_seen),  32'h77);
        @(negedge clk);
        chk("stall single write", 32'(v_cea), 32'd0);

        // Reset while word 5 is on the port
        run_fill(2'd0, 8'h00, 10'h000, 11'd0);
        @(negedge clk);
        mode = 2'd1; fill_value = 8'h00; base = 10'h000; length = 11'd20; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            if (k > 1) @(negedge clk);
            if (v_cea && v_ada == 10'h005) begin
                found = 1'b1;
                break;
            end
        end
        chk("abort reached idx5", 32'(found), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort v_cea", 32'(v_cea), 32'd0);
        chk("abort v_ada", 32'(v_ada), 32'd0);
        chk("abort v_din", 32'(v_din), 32'd0);
        chk("abort busy",  32'(busy),  32'd0);
        chk("abort done",  32'(done),  32'd0);
        rst = 1'b0;
        done_seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (done || v_cea) done_seen++;
        end
        chk("abort no done/writes", 32'(done_seen), 32'd0);
        run_fill(2'd0, 8'h3C, 10'h010, 11'd2);
        chk("restart writes",     32'(nw),       32'd2);
        chk("restart done cycle", 32'(done_k),   32'd3);
        chk("restart addr[1]",    32'(cap_a[1]), 32'h011);
        chk("restart data[1]",    32'(cap_d[1]), 32'h3C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
